// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM controller command port between two masters (for example
// the bootstrap copy engine and the AHB slave path). A winning command is
// latched, issued as a one-cycle strobe, and the arbiter waits for the
// controller ack. Read data is captured one cycle after the ack, and a
// one-cycle ack is returned to the granted master. An optional watchdog ends
// a WAIT that never sees an ack and reports it through mN_err.
//
// Ports
//   HCLK, HRESETN            clock, asynchronous active-low reset
//   mN_req/write/size/addr/wdata  master N command (held until mN_ack)
//   mN_ack, mN_err, mN_rdata      master N completion, error flag, read data
//   ahbsram_req/write/size/addr/wdata  command to the SRAM controller
//   sramahb_ack, sramahb_rdata        controller completion, read data
//   BUSY                     controller busy; blocks issue in IDLE only
//   grant_id                 master owning the current or last transaction
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int AHB_DWIDTH     = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [2:0]            m0_size,
    input  logic [19:0]           m0_addr,
    input  logic [AHB_DWIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [AHB_DWIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [2:0]            m1_size,
    input  logic [19:0]           m1_addr,
    input  logic [AHB_DWIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [AHB_DWIDTH-1:0] m1_rdata,
    output logic                  ahbsram_req,
    output logic                  ahbsram_write,
    output logic [2:0]            ahbsram_size,
    output logic [19:0]           ahbsram_addr,
    output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
    input  logic                  sramahb_ack,
    input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
    input  logic                  BUSY,
    output logic                  grant_id
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPT,
        ST_RESP
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  grant_q;
    logic                  req_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [19:0]           addr_q;
    logic [AHB_DWIDTH-1:0] wdata_q;
    logic                  ack0_q, ack1_q;
    logic                  err0_q, err1_q;
    logic [AHB_DWIDTH-1:0] rdata0_q, rdata1_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pick_m1_d;

    // Winner for the current IDLE cycle. On contention, round-robin hands
    // the grant to the master that did not win last time.
    always_comb begin
        pick_m1_d = m1_req;
        if (m0_req && m1_req) begin
            pick_m1_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            req_q        <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            cnt_q        <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            req_q  <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((m0_req || m1_req) && !BUSY) begin
                        grant_q      <= pick_m1_d;
                        last_grant_q <= pick_m1_d;
                        write_q      <= pick_m1_d ? m1_write : m0_write;
                        size_q       <= pick_m1_d ? m1_size  : m0_size;
                        addr_q       <= pick_m1_d ? m1_addr  : m0_addr;
                        wdata_q      <= pick_m1_d ? m1_wdata : m0_wdata;
                        req_q        <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sramahb_ack) begin
                        state_q <= ST_CAPT;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TMO_LAST))) begin
                        // Timeout: complete with err=1; a timed-out read returns 0.
                        if (grant_q) begin
                            ack1_q <= 1'b1;
                            err1_q <= 1'b1;
                            if (!write_q) rdata1_q <= '0;
                        end else begin
                            ack0_q <= 1'b1;
                            err0_q <= 1'b1;
                            if (!write_q) rdata0_q <= '0;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPT: begin
                    // Controller read data is valid this cycle (one after ack).
                    if (grant_q) begin
                        ack1_q <= 1'b1;
                        if (!write_q) rdata1_q <= sramahb_rdata;
                    end else begin
                        ack0_q <= 1'b1;
                        if (!write_q) rdata0_q <= sramahb_rdata;
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    // Requests are not sampled here, so the master being
                    // acked cannot be granted twice for one command.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack        = ack0_q;
    assign m0_err        = err0_q;
    assign m0_rdata      = rdata0_q;
    assign m1_ack        = ack1_q;
    assign m1_err        = err1_q;
    assign m1_rdata      = rdata1_q;
    assign ahbsram_req   = req_q;
    assign ahbsram_write = write_q;
    assign ahbsram_size  = size_q;
    assign ahbsram_addr  = addr_q;
    assign ahbsram_wdata = wdata_q;
    assign grant_id      = grant_q;

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Two-requester arbiter that shares one SRAM controller command interface (req/write/size/addr/wdata in, ack/rdata/BUSY out) between two masters, e.g. the bootstrap copy engine and the AHB slave path.
- Latches one command, issues it as a single-cycle request, waits for the ack, captures read data one cycle after ack, and returns a one-cycle ack to the granted master.
- Supports round-robin or fixed priority, gates issue on BUSY, and has an ack watchdog.

Parameters:
- AHB_DWIDTH, 32, data width of all wdata/rdata buses.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a simultaneous request.
- TIMEOUT_CYCLES, 16, WAIT-state watchdog limit in cycles; 0 disables the watchdog.

Ports:
- HCLK  in  1  clock.
- HRESETN  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held high with command stable until m0_ack.
- m0_write  in  1  1 = write, 0 = read.
- m0_size  in  3  000 byte, 001 half, 010 word.
- m0_addr  in  20  byte address.
- m0_wdata  in  AHB_DWIDTH  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; 1 = watchdog timeout.
- m0_rdata  out  AHB_DWIDTH  read data; valid with m0_ack, held until the next m0 read completion.
- m1_req, m1_write, m1_size, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0_*, for master 1.
- ahbsram_req  out  1  one-cycle command strobe to the SRAM controller.
- ahbsram_write  out  1  latched write flag.
- ahbsram_size  out  3  latched size.
- ahbsram_addr  out  20  latched address.
- ahbsram_wdata  out  AHB_DWIDTH  latched write data.
- sramahb_ack  in  1  controller completion pulse.
- sramahb_rdata  in  AHB_DWIDTH  controller read data; valid the cycle after sramahb_ack.
- BUSY  in  1  SRAM busy; no new command is issued while high.
- grant_id  out  1  master owning the current or last transaction.

Behaviour:
- Reset (async, HRESETN=0): state IDLE.
  - All ack/err/req outputs 0.
  - m0_rdata, m1_rdata, ahbsram_addr/size/wdata/write all 0.
  - grant_id=0; last_grant=1, so master 0 wins the first contention.
  - Watchdog counter 0.
  - Reset mid-transaction abandons it; no ack is issued afterwards.
- FSM states: IDLE, ISSUE, WAIT, CAPT, RESP. All outputs are registered.
- IDLE:
  - If (m0_req | m1_req) and BUSY=0: select winner, latch its command into ahbsram_* regs, set grant_id, go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection:
  - Only one requester: that one.
  - Both, FIXED_PRIO=1: master 0.
  - Both, FIXED_PRIO=0: the master != last_grant. last_grant updates at grant.
- ISSUE: ahbsram_req=1 for exactly this cycle; go to WAIT, counter cleared.
- WAIT:
  - ahbsram_req=0; ahbsram_* stay stable.
  - sramahb_ack=1 → go to CAPT.
  - Otherwise counter++. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 → go to RESP with err=1.
- CAPT: if the latched command is a read, register sramahb_rdata into grant_id's mN_rdata; go to RESP with err=0.
- RESP:
  - mN_ack=1 for grant_id only, this cycle only; mN_err as determined.
  - Timeout read: mN_rdata is set to 0.
  - Write completion leaves mN_rdata unchanged.
  - Next state IDLE. The acked master's req is not sampled during RESP, so no double grant.
- Latency: req sampled in IDLE at cycle 0 → ahbsram_req at cycle 1 → controller ack at cycle 2 → CAPT cycle 3 → mN_ack at cycle 4. Next grant no earlier than cycle 5.
- Requests arriving during ISSUE..RESP wait in IDLE; there is no queueing beyond the req level.
- If a master drops req before its ack, the latched command still completes and the ack still pulses.
- sramahb_ack outside WAIT is ignored.
- BUSY is sampled only in IDLE; once issued, a command is never cancelled by BUSY.

Test Plan:
- Single read: m0 reads addr 0x00010, SRAM model returns 0xDEADBEEF one cycle after ack → ahbsram_req high only at cycle 1; m0_ack at cycle 4, m0_err=0, m0_rdata=0xDEADBEEF.
- Byte write: m1 write, size 000, addr 0x00003, wdata 0x000000A5 → ahbsram_* carry m1's values from cycle 1 until RESP; m1_ack at cycle 4; m1_rdata unchanged.
- Contention, FIXED_PRIO=0: m0 and m1 both hold req → grants m0, m1, m0, m1; grant_id alternates; each ack pulses exactly once. With FIXED_PRIO=1, m0 is granted every time it requests.
- BUSY gating: BUSY=1 for 10 cycles while m0_req=1 → no ahbsram_req during that window; ahbsram_req on the cycle after BUSY falls.
- Watchdog: model never acks, TIMEOUT_CYCLES=16, m0 read → m0_ack with m0_err=1 and m0_rdata=0 after the WAIT count reaches TIMEOUT_CYCLES-1; arbiter returns to IDLE and serves m1 next.
- Reset mid-WAIT: assert HRESETN=0 in WAIT → all outputs 0 immediately; no m0_ack after release; m0 wins the next contention.
